// File: rtl/lq_miss_ctrl.sv
// lq_miss_ctrl: MSHR table for load-queue misses plus arbitration of the single
// data-memory port between those loads and retiring stores.
// Optional feature: define LQ_MISS_MERGE_EN to let a request whose aligned address
// hits an outstanding miss piggy-back on it instead of allocating a new entry.
module lq_miss_ctrl #(
  parameter int unsigned MSHR_SIZE  = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic             clock,
  input  logic             reset,
  // load-miss requests from the LQ
  input  logic             ld_req_valid,
  input  logic [63:0]      ld_req_addr,
  output logic             ld_req_ready,
  // retiring store
  input  logic             st_req_valid,
  input  logic [63:0]      st_req_addr,
  input  logic [63:0]      st_req_data,
  output logic             st_req_done,
  // memory port
  output logic [1:0]       proc2Dmem_command,
  output logic [63:0]      proc2Dmem_addr,
  output logic [63:0]      proc2Dmem_data,
  input  logic [TAG_W-1:0] Dmem2proc_response,
  input  logic [63:0]      Dmem2proc_data,
  input  logic [TAG_W-1:0] Dmem2proc_tag,
  // fill broadcast to the LQ
  output logic             lq_miss_valid,
  output logic [63:0]      lq_miss_addr,
  output logic [63:0]      lq_miss_data,
  output logic             mshr_full
);

  localparam int unsigned IdxW = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1;
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] BusNone  = 2'd0;
  localparam logic [1:0] BusLoad  = 2'd1;
  localparam logic [1:0] BusStore = 2'd2;

  localparam logic [63:0] AlignMask = ~64'h7;

  typedef enum logic [1:0] {StEmpty, StPending, StIssued} ent_st_e;

  // MSHR table
  ent_st_e          st_q   [MSHR_SIZE];
  ent_st_e          st_d   [MSHR_SIZE];
  logic [63:0]      addr_q [MSHR_SIZE];
  logic [63:0]      addr_d [MSHR_SIZE];
  logic [TAG_W-1:0] tag_q  [MSHR_SIZE];
  logic [TAG_W-1:0] tag_d  [MSHR_SIZE];

  logic [CntW-1:0]  starve_q, starve_d;

  logic             fill_valid_q, fill_valid_d;
  logic [63:0]      fill_addr_q, fill_addr_d;
  logic [63:0]      fill_data_q, fill_data_d;

  // decoded table status
  logic             any_empty, any_pend, ret_hit, merge_hit;
  logic [IdxW-1:0]  empty_idx, pend_idx, ret_idx;
  logic [63:0]      ld_addr_al;

  // arbitration
  logic             force_load, store_win, load_win, mem_acc, alloc;

  assign ld_addr_al = ld_req_addr & AlignMask;
  assign mem_acc    = (Dmem2proc_response != '0);

  // Lowest-index EMPTY / PENDING entries, tag-return match and optional merge match.
  always_comb begin
    any_empty = 1'b0;
    empty_idx = '0;
    any_pend  = 1'b0;
    pend_idx  = '0;
    ret_hit   = 1'b0;
    ret_idx   = '0;
    merge_hit = 1'b0;
    // descending scan so the lowest index is the last one written
    for (int i = MSHR_SIZE - 1; i >= 0; i--) begin
      if (st_q[i] == StEmpty) begin
        any_empty = 1'b1;
        empty_idx = IdxW'(i);
      end
      if (st_q[i] == StPending) begin
        any_pend = 1'b1;
        pend_idx = IdxW'(i);
      end
      if ((Dmem2proc_tag != '0) && (st_q[i] == StIssued) && (tag_q[i] == Dmem2proc_tag)) begin
        ret_hit = 1'b1;
        ret_idx = IdxW'(i);
      end
`ifdef LQ_MISS_MERGE_EN
      if ((st_q[i] != StEmpty) && (addr_q[i] == ld_addr_al)) begin
        merge_hit = 1'b1;
      end
`endif
    end
  end

  // Memory-port arbitration: store first unless a pending load has starved too long.
  always_comb begin
    force_load = any_pend && (starve_q == CntW'(STARVE_MAX));
    store_win  = st_req_valid && !force_load;
    load_win   = !store_win && any_pend;
    alloc      = ld_req_valid && any_empty && !merge_hit;
  end

  // Memory-port and handshake outputs.
  always_comb begin
    proc2Dmem_command = BusNone;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    st_req_done       = 1'b0;
    if (store_win) begin
      proc2Dmem_command = BusStore;
      proc2Dmem_addr    = st_req_addr & AlignMask;
      proc2Dmem_data    = st_req_data;
      st_req_done       = mem_acc;
    end else if (load_win) begin
      proc2Dmem_command = BusLoad;
      proc2Dmem_addr    = addr_q[pend_idx];
    end
    ld_req_ready = any_empty || merge_hit;
    mshr_full    = !any_empty;
  end

  // Starvation counter: counts store wins that delay a pending load.
  always_comb begin
    starve_d = starve_q;
    if (!any_pend) begin
      starve_d = '0;
    end else if (load_win && mem_acc) begin
      starve_d = '0;
    end else if (store_win && (starve_q != CntW'(STARVE_MAX))) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  // Table next state; issue, return and alloc always touch different entries
  // because each acts on a distinct registered state.
  always_comb begin
    for (int i = 0; i < MSHR_SIZE; i++) begin
      st_d[i]   = st_q[i];
      addr_d[i] = addr_q[i];
      tag_d[i]  = tag_q[i];
    end
    if (load_win && mem_acc) begin
      st_d[pend_idx]  = StIssued;
      tag_d[pend_idx] = Dmem2proc_response;
    end
    if (ret_hit) begin
      st_d[ret_idx] = StEmpty;
    end
    if (alloc) begin
      st_d[empty_idx]   = StPending;
      addr_d[empty_idx] = ld_addr_al;
    end
  end

  // Fill pulse next state; address/data hold when no tag matches.
  always_comb begin
    fill_valid_d = ret_hit;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    if (ret_hit) begin
      fill_addr_d = addr_q[ret_idx];
      fill_data_d = Dmem2proc_data;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        st_q[i]   <= StEmpty;
        addr_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      starve_q     <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        st_q[i]   <= st_d[i];
        addr_q[i] <= addr_d[i];
        tag_q[i]  <= tag_d[i];
      end
      starve_q     <= starve_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
    end
  end

  assign lq_miss_valid = fill_valid_q;
  assign lq_miss_addr  = fill_addr_q;
  assign lq_miss_data  = fill_data_q;

endmodule

// File: tb/tb_lq_miss_ctrl.sv
// Directed bench for lq_miss_ctrl: inputs change 1 time unit after the rising edge,
// outputs are compared 1 time unit later.
module tb_lq_miss_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ld_req_valid;
  logic [63:0] ld_req_addr;
  logic        ld_req_ready;
  logic        st_req_valid;
  logic [63:0] st_req_addr;
  logic [63:0] st_req_data;
  logic        st_req_done;
  logic [1:0]  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;
  logic        lq_miss_valid;
  logic [63:0] lq_miss_addr;
  logic [63:0] lq_miss_data;
  logic        mshr_full;

  int total = 0;
  int bad   = 0;

  lq_miss_ctrl #(
    .MSHR_SIZE (4),
    .TAG_W     (4),
    .STARVE_MAX(8)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .ld_req_valid      (ld_req_valid),
    .ld_req_addr       (ld_req_addr),
    .ld_req_ready      (ld_req_ready),
    .st_req_valid      (st_req_valid),
    .st_req_addr       (st_req_addr),
    .st_req_data       (st_req_data),
    .st_req_done       (st_req_done),
    .proc2Dmem_command (proc2Dmem_command),
    .proc2Dmem_addr    (proc2Dmem_addr),
    .proc2Dmem_data    (proc2Dmem_data),
    .Dmem2proc_response(Dmem2proc_response),
    .Dmem2proc_data    (Dmem2proc_data),
    .Dmem2proc_tag     (Dmem2proc_tag),
    .lq_miss_valid     (lq_miss_valid),
    .lq_miss_addr      (lq_miss_addr),
    .lq_miss_data      (lq_miss_data),
    .mshr_full         (mshr_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] tags [4];
    ld_req_valid       = 1'b0;
    ld_req_addr        = '0;
    st_req_valid       = 1'b0;
    st_req_addr        = '0;
    st_req_data        = '0;
    Dmem2proc_response = '0;
    Dmem2proc_data     = '0;
    Dmem2proc_tag      = '0;

    // ---- reset values
    step();
    step();
    #1;
    chk("rst_cmd",   proc2Dmem_command, 0);
    chk("rst_addr",  proc2Dmem_addr, 0);
    chk("rst_data",  proc2Dmem_data, 0);
    chk("rst_ready", ld_req_ready, 1);
    chk("rst_full",  mshr_full, 0);
    chk("rst_done",  st_req_done, 0);
    chk("rst_fillv", lq_miss_valid, 0);
    chk("rst_filla", lq_miss_addr, 0);
    chk("rst_filld", lq_miss_data, 0);
    reset = 1'b1;
    step();

    // ---- 1: single miss round trip
    ld_req_valid = 1'b1;
    ld_req_addr  = 64'h1000;
    #1;
    chk("t1_ready", ld_req_ready, 1);
    chk("t1_cmd_idle", proc2Dmem_command, 0);
    step();
    ld_req_valid       = 1'b0;
    Dmem2proc_response = 4'd3;
    #1;
    chk("t1_cmd_load", proc2Dmem_command, 1);
    chk("t1_addr", proc2Dmem_addr, 64'h1000);
    step();
    Dmem2proc_response = 4'd0;
    #1;
    chk("t1_cmd_issued", proc2Dmem_command, 0);
    repeat (4) step();
    Dmem2proc_tag  = 4'd3;
    Dmem2proc_data = 64'hDEAD;
    #1;
    chk("t1_fill_early", lq_miss_valid, 0);
    step();
    Dmem2proc_tag  = 4'd0;
    Dmem2proc_data = 64'h0;
    #1;
    chk("t1_fill_v", lq_miss_valid, 1);
    chk("t1_fill_a", lq_miss_addr, 64'h1000);
    chk("t1_fill_d", lq_miss_data, 64'hDEAD);
    step();
    chk("t1_fill_off", lq_miss_valid, 0);
    chk("t1_hold_a", lq_miss_addr, 64'h1000);
    chk("t1_hold_d", lq_miss_data, 64'hDEAD);

    // ---- 2: fill the table, then free one entry
    for (int i = 0; i < 4; i++) begin
      ld_req_valid = 1'b1;
      ld_req_addr  = 64'h100 + 64'(8 * i);
      #1;
      chk("t2_ready_alloc", ld_req_ready, 1);
      step();
    end
    ld_req_valid = 1'b0;
    #1;
    chk("t2_full", mshr_full, 1);
    chk("t2_not_ready", ld_req_ready, 0);
    tags[0] = 4'd1;
    tags[1] = 4'd2;
    tags[2] = 4'd4;
    tags[3] = 4'd5;
    for (int i = 0; i < 4; i++) begin
      Dmem2proc_response = tags[i];
      #1;
      chk("t2_issue_cmd", proc2Dmem_command, 1);
      chk("t2_issue_addr", proc2Dmem_addr, 64'h100 + 64'(8 * i));
      step();
    end
    Dmem2proc_response = 4'd0;
    #1;
    chk("t2_all_issued", proc2Dmem_command, 0);
    chk("t2_still_full", mshr_full, 1);
    Dmem2proc_tag  = 4'd2;
    Dmem2proc_data = 64'h22;
    step();
    Dmem2proc_tag = 4'd0;
    #1;
    chk("t2_ret_v", lq_miss_valid, 1);
    chk("t2_ret_a", lq_miss_addr, 64'h108);
    chk("t2_ret_d", lq_miss_data, 64'h22);
    chk("t2_ready_again", ld_req_ready, 1);
    chk("t2_not_full", mshr_full, 0);
    // drain the rest
    Dmem2proc_tag  = 4'd1;
    Dmem2proc_data = 64'h11;
    step();
    #1;
    chk("t2_drain0", lq_miss_addr, 64'h100);
    Dmem2proc_tag  = 4'd4;
    Dmem2proc_data = 64'h44;
    step();
    #1;
    chk("t2_drain2", lq_miss_addr, 64'h110);
    Dmem2proc_tag  = 4'd5;
    Dmem2proc_data = 64'h55;
    step();
    Dmem2proc_tag = 4'd0;
    #1;
    chk("t2_drain3_a", lq_miss_addr, 64'h118);
    chk("t2_drain3_d", lq_miss_data, 64'h55);
    step();
    chk("t2_drain_off", lq_miss_valid, 0);

    // ---- 3: memory refuses three times, accepts on the fourth
    ld_req_valid = 1'b1;
    ld_req_addr  = 64'h3000;
    step();
    ld_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_retry_cmd", proc2Dmem_command, 1);
      chk("t3_retry_addr", proc2Dmem_addr, 64'h3000);
      step();
    end
    Dmem2proc_response = 4'd6;
    #1;
    chk("t3_acc_cmd", proc2Dmem_command, 1);
    chk("t3_acc_addr", proc2Dmem_addr, 64'h3000);
    step();
    Dmem2proc_response = 4'd0;
    #1;
    chk("t3_after_acc", proc2Dmem_command, 0);
    Dmem2proc_tag  = 4'd6;
    Dmem2proc_data = 64'h33;
    step();
    Dmem2proc_tag = 4'd0;
    #1;
    chk("t3_fill_a", lq_miss_addr, 64'h3000);
    chk("t3_fill_d", lq_miss_data, 64'h33);

    // ---- 4: store starvation of two queued loads
    st_req_valid       = 1'b1;
    st_req_addr        = 64'h4004;
    st_req_data        = 64'h55;
    Dmem2proc_response = 4'd1;
    ld_req_valid       = 1'b1;
    ld_req_addr        = 64'h4800;
    #1;
    chk("t4_c0_cmd", proc2Dmem_command, 2);
    chk("t4_c0_addr", proc2Dmem_addr, 64'h4000);
    step();
    ld_req_addr = 64'h4900;
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk("t4_store_cmd", proc2Dmem_command, 2);
      chk("t4_store_done", st_req_done, 1);
      chk("t4_store_data", proc2Dmem_data, 64'h55);
      step();
      ld_req_valid = 1'b0;
    end
    Dmem2proc_response = 4'd7;
    #1;
    chk("t4_forced_cmd", proc2Dmem_command, 1);
    chk("t4_forced_addr", proc2Dmem_addr, 64'h4800);
    chk("t4_forced_done", st_req_done, 0);
    chk("t4_forced_data", proc2Dmem_data, 0);
    step();
    Dmem2proc_response = 4'd1;
    for (int c = 10; c <= 17; c++) begin
      #1;
      chk("t4_store2_cmd", proc2Dmem_command, 2);
      step();
    end
    Dmem2proc_response = 4'd8;
    #1;
    chk("t4_forced2_cmd", proc2Dmem_command, 1);
    chk("t4_forced2_addr", proc2Dmem_addr, 64'h4900);
    step();
    st_req_valid       = 1'b0;
    Dmem2proc_response = 4'd0;
    #1;
    chk("t4_idle", proc2Dmem_command, 0);
    Dmem2proc_tag  = 4'd7;
    Dmem2proc_data = 64'h47;
    step();
    #1;
    chk("t4_ret7", lq_miss_addr, 64'h4800);
    Dmem2proc_tag  = 4'd8;
    Dmem2proc_data = 64'h48;
    step();
    Dmem2proc_tag = 4'd0;
    #1;
    chk("t4_ret8", lq_miss_addr, 64'h4900);

    // ---- 5: two requests to the same aligned doubleword
    ld_req_valid = 1'b1;
    ld_req_addr  = 64'h2008;
    #1;
    chk("t5_ready0", ld_req_ready, 1);
    step();
    ld_req_addr        = 64'h200C;
    Dmem2proc_response = 4'd9;
    #1;
    chk("t5_cmd_first", proc2Dmem_command, 1);
    chk("t5_addr_first", proc2Dmem_addr, 64'h2008);
    chk("t5_ready1", ld_req_ready, 1);
    step();
    ld_req_valid       = 1'b0;
    Dmem2proc_response = 4'd10;
    #1;
`ifdef LQ_MISS_MERGE_EN
    chk("t5_no_second", proc2Dmem_command, 0);
`else
    chk("t5_second_cmd", proc2Dmem_command, 1);
    chk("t5_second_addr", proc2Dmem_addr, 64'h2008);
`endif
    step();
    Dmem2proc_response = 4'd0;
    #1;
    chk("t5_idle", proc2Dmem_command, 0);
    Dmem2proc_tag  = 4'd9;
    Dmem2proc_data = 64'h99;
    step();
    Dmem2proc_tag  = 4'd10;
    Dmem2proc_data = 64'hAA;
    #1;
    chk("t5_fill1_v", lq_miss_valid, 1);
    chk("t5_fill1_a", lq_miss_addr, 64'h2008);
    chk("t5_fill1_d", lq_miss_data, 64'h99);
    step();
    Dmem2proc_tag = 4'd0;
    #1;
`ifdef LQ_MISS_MERGE_EN
    chk("t5_fill2_none", lq_miss_valid, 0);
`else
    chk("t5_fill2_v", lq_miss_valid, 1);
    chk("t5_fill2_d", lq_miss_data, 64'hAA);
`endif
    step();

    // ---- 6: reset drops an issued miss; its late tag is ignored
    ld_req_valid = 1'b1;
    ld_req_addr  = 64'h6000;
    step();
    ld_req_valid       = 1'b0;
    Dmem2proc_response = 4'd5;
    #1;
    chk("t6_issue", proc2Dmem_command, 1);
    step();
    Dmem2proc_response = 4'd0;
    reset              = 1'b0;
    #1;
    chk("t6_rst_ready", ld_req_ready, 1);
    chk("t6_rst_cmd", proc2Dmem_command, 0);
    chk("t6_rst_filla", lq_miss_addr, 0);
    step();
    step();
    reset = 1'b1;
    step();
    Dmem2proc_tag  = 4'd5;
    Dmem2proc_data = 64'h66;
    step();
    Dmem2proc_tag = 4'd0;
    #1;
    chk("t6_no_fill", lq_miss_valid, 0);
    chk("t6_fill_addr", lq_miss_addr, 0);
    chk("t6_cmd", proc2Dmem_command, 0);
    chk("t6_full", mshr_full, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
